shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//  Shares one bit-serial 32-bit shift register between two requesters.
//  A round-robin arbiter accepts one request. An FSM then shifts the
//  operand one bit per clock for the requested amount and reports
//  completion with a done pulse. It fronts the serial shift datapath, so
//  the CPU and DMA-side logic never drive the shifter directly.
// PARAMETERS
//  WIDTH  32  operand/result width in bits
//  SHW    5   shift-amount width; must satisfy 2**SHW >= WIDTH
// PORTS
//  clock   in   1      single clock, all state updates on rising edge
//  reset   in   1      synchronous, active-high
//  req0    in   1      requester 0 valid; held until gnt0
//  data0   in   WIDTH  requester 0 operand
//  amt0    in   SHW    requester 0 shift amount (0..WIDTH-1)
//  op0     in   2      requester 0 op: 00 LLS, 01 LRS, 10 ARS, 11 ROL
//  req1    in   1      requester 1 valid; held until gnt1
//  data1   in   WIDTH  requester 1 operand
//  amt1    in   SHW    requester 1 shift amount
//  op1     in   2      requester 1 op (same encoding as op0)
//  gnt0    out  1      combinational accept pulse for requester 0
//  gnt1    out  1      combinational accept pulse for requester 1
//  busy    out  1      high from the cycle after accept through DONE
//  done    out  1      one-cycle completion pulse
//  owner   out  1      index of requester that owns the current op/result
//  result  out  WIDTH  working register; valid from done until next accept
// BEHAVIOUR
//  - Reset values: state IDLE, result 0, count 0, owner 0, done 0,
//    busy 0, gnt0/gnt1 0. The round-robin pointer "last" resets to 1,
//    so requester 0 wins the first tie.
//  - FSM states: IDLE, SHIFT, DONE.
//  - IDLE:
//    * Requesting ports are arbitrated. A single request is granted.
//    * If both ports request, the grant goes to the port != last.
//    * On grant: gnt_i=1 in this cycle. At the edge: result<=data_i,
//      count<=amt_i, opreg<=op_i, owner<=i, last<=i, state->SHIFT.
//  - SHIFT, count!=0: one 1-bit step per clock, then count<=count-1.
//    * LLS: {r[W-2:0],0}
//    * LRS: {0,r[W-1:1]}
//    * ARS: {r[W-1],r[W-1:1]}
//    * ROL: {r[W-2:0],r[W-1]}
//  - SHIFT, count==0: state->DONE; result unchanged.
//  - DONE: done=1 and busy=1 for exactly one cycle, then state->IDLE.
//    No grant is issued in DONE.
//  - Latency: request accepted in cycle T -> done high in cycle T+amt+2.
//    amt=0 gives done at T+2 with result == operand. Back-to-back
//    throughput is therefore one op per amt+3 cycles.
//  - gnt0/gnt1 are 0 in SHIFT and DONE. Requests arriving then wait,
//    with no loss and no queuing beyond the requester's held req.
//  - Operand and amount ports are sampled only at the grant edge; later
//    changes have no effect.
//  - amt >= WIDTH is out of contract. The FSM still executes amt steps;
//    the result is defined by the bit rules above.
//  - result holds its value after DONE until the next grant edge.
//  - done and busy are decoded from the registered state (glitch-free).
//  - Reset mid-operation (any state): the next cycle is IDLE with all
//    reset values. The aborted op never produces done.
//  - Simultaneous reset and req: reset wins; no grant is issued.
// TESTING
//  1. req0 data=0x000000F1 amt=4 op=LLS at T
//     -> gnt0@T, done@T+6, result=0x00000F10, owner=0.
//  2. req1 data=0x80000000 amt=31 op=ARS
//     -> done@T+33, result=0xFFFFFFFF, owner=1.
//  3. req0 data=0x12345678 amt=0 op=ROL
//     -> done@T+2, result=0x12345678; then ROL 0x80000001 amt=1
//     -> 0x00000003.
//  4. req0 and req1 held high continuously, each amt=1 LRS
//     -> grant order 0,1,0,1; one done per 4 cycles.
//  5. reset high for 1 cycle mid-SHIFT (amt=20, after 5 steps)
//     -> next cycle busy=0, result=0, no done; a following req0 completes
//     normally.
//  6. req1 raised while busy on an op for requester 0
//     -> gnt1=0 until IDLE, gnt1 in the cycle after done; LRS 0xF0000000
//     amt=4 -> 0x0F000000.

Source files
------------

// File: rtl/shift_sequencer.sv
// Round-robin front end for a shared bit-serial 32-bit shifter.
// One request is accepted, shifted one bit per clock, then done pulses.
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic [SHW-1:0]   amt0,
  input  logic [1:0]       op0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  input  logic [SHW-1:0]   amt1,
  input  logic [1:0]       op1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             owner,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [SHW-1:0]   count;
  logic [1:0]       opreg;
  logic             last;
  logic             idle;
  logic [WIDTH-1:0] step;

  // Reset masks the grant so a request seen with reset is never accepted.
  assign idle = (state == IDLE) && !reset;
  assign gnt0 = idle && req0 && (!req1 || last);
  assign gnt1 = idle && req1 && (!req0 || !last);
  assign busy = (state == SHIFT) || (state == DONE);
  assign done = (state == DONE);

  always_comb begin
    step = result;
    unique case (opreg)
      2'b00: step = {result[WIDTH-2:0], 1'b0};
      2'b01: step = {1'b0, result[WIDTH-1:1]};
      2'b10: step = {result[WIDTH-1], result[WIDTH-1:1]};
      2'b11: step = {result[WIDTH-2:0], result[WIDTH-1]};
      default: step = result;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      result <= '0;
      count  <= '0;
      opreg  <= 2'b00;
      owner  <= 1'b0;
      last   <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            result <= gnt1 ? data1 : data0;
            count  <= gnt1 ? amt1 : amt0;
            opreg  <= gnt1 ? op1 : op0;
            owner  <= gnt1;
            last   <= gnt1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (count != '0) begin
            result <= step;
            count  <= count - 1'b1;
          end else begin
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer.
// Inputs change at posedge+1, outputs are sampled at posedge+2.
module tb_shift_sequencer;

  logic        clock = 0;
  logic        reset = 1;
  logic        req0 = 0, req1 = 0;
  logic [31:0] data0 = 0, data1 = 0;
  logic [4:0]  amt0 = 0, amt1 = 0;
  logic [1:0]  op0 = 0, op1 = 0;
  logic        gnt0, gnt1, busy, done, owner;
  logic [31:0] result;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;

  shift_sequencer dut (
    .clock(clock), .reset(reset),
    .req0(req0), .data0(data0), .amt0(amt0), .op0(op0),
    .req1(req1), .data1(data1), .amt1(amt1), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .owner(owner), .result(result)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Stimulus only: issue one request, return latency and final outputs.
  task automatic run_op(input bit p, input logic [31:0] d,
                        input logic [4:0] a, input logic [1:0] o,
                        output int lat, output logic [31:0] res,
                        output logic own, output bit to);
    int  t0;
    bit  g;
    g = 0;
    if (p) begin
      req1 = 1; data1 = d; amt1 = a; op1 = o;
    end else begin
      req0 = 1; data0 = d; amt0 = a; op0 = o;
    end
    #1;
    for (int i = 0; i < 200; i++) begin
      if ((p ? gnt1 : gnt0) === 1'b1) begin
        g = 1;
        break;
      end
      @(posedge clock); #2;
    end
    t0 = cyc;
    @(posedge clock); #1;
    if (p) begin
      req1 = 0; data1 = ~d; amt1 = ~a; op1 = ~o;
    end else begin
      req0 = 0; data0 = ~d; amt0 = ~a; op0 = ~o;
    end
    #1;
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) break;
      @(posedge clock); #2;
    end
    lat = cyc - t0;
    res = result;
    own = owner;
    to  = !g || (done !== 1'b1);
  endtask

  task automatic test_reset;
    reset = 1; req0 = 1;
    @(posedge clock); #1;
    #1;
    vectors++;
    if (gnt0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_gnt: gnt0=%b want 0", gnt0);
    end
    @(posedge clock); #1;
    req0 = 0; reset = 0;
    #1;
    vectors++;
    if ({busy, done, owner, gnt0, gnt1} !== 5'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_vals: busy=%b done=%b owner=%b gnt=%b%b result=%h want all 0",
               busy, done, owner, gnt0, gnt1, result);
    end
  endtask

  task automatic test_lls;
    int lat; logic [31:0] res; logic own; bit to;
    run_op(0, 32'h000000F1, 5'd4, 2'b00, lat, res, own, to);
    vectors++;
    if (to || lat !== 6 || res !== 32'h00000F10 || own !== 1'b0) begin
      errors++;
      $display("FAIL lls: to=%b lat=%0d res=%h own=%b want lat=6 res=00000f10 own=0",
               to, lat, res, own);
    end
    @(posedge clock); #2;
    @(posedge clock); #2;
    vectors++;
    if (result !== 32'h00000F10 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL hold: result=%h busy=%b done=%b want 00000f10 0 0",
               result, busy, done);
    end
  endtask

  task automatic test_ars;
    int lat; logic [31:0] res; logic own; bit to;
    run_op(1, 32'h80000000, 5'd31, 2'b10, lat, res, own, to);
    vectors++;
    if (to || lat !== 33 || res !== 32'hFFFFFFFF || own !== 1'b1) begin
      errors++;
      $display("FAIL ars: to=%b lat=%0d res=%h own=%b want lat=33 res=ffffffff own=1",
               to, lat, res, own);
    end
  endtask

  task automatic test_rol;
    int lat; logic [31:0] res; logic own; bit to;
    run_op(0, 32'h12345678, 5'd0, 2'b11, lat, res, own, to);
    vectors++;
    if (to || lat !== 2 || res !== 32'h12345678 || own !== 1'b0) begin
      errors++;
      $display("FAIL rol0: to=%b lat=%0d res=%h own=%b want lat=2 res=12345678 own=0",
               to, lat, res, own);
    end
    run_op(0, 32'h80000001, 5'd1, 2'b11, lat, res, own, to);
    vectors++;
    if (to || lat !== 3 || res !== 32'h00000003) begin
      errors++;
      $display("FAIL rol1: to=%b lat=%0d res=%h want lat=3 res=00000003",
               to, lat, res);
    end
  endtask

  task automatic test_back_to_back;
    int          gc[4]; bit gp[4];
    int          dc[4]; logic [31:0] dr[4];
    int          ng, nd;
    logic [31:0] want;
    ng = 0; nd = 0;
    @(posedge clock); #1; reset = 1;
    @(posedge clock); #1; reset = 0;
    req0 = 1; data0 = 32'h8;   amt0 = 1; op0 = 2'b01;
    req1 = 1; data1 = 32'h100; amt1 = 1; op1 = 2'b01;
    #1;
    for (int i = 0; i < 40; i++) begin
      if ((gnt0 || gnt1) && ng < 4) begin
        gc[ng] = cyc; gp[ng] = gnt1; ng++;
      end
      if (done === 1'b1 && nd < 4) begin
        dc[nd] = cyc; dr[nd] = result; nd++;
      end
      if (nd == 4) break;
      @(posedge clock); #2;
    end
    req0 = 0; req1 = 0;
    vectors++;
    if (ng != 4 || nd != 4) begin
      errors++;
      $display("FAIL b2b_count: grants=%0d dones=%0d want 4 4", ng, nd);
    end else begin
      for (int k = 0; k < 4; k++) begin
        want = k[0] ? 32'h80 : 32'h4;
        vectors++;
        if (gp[k] !== k[0] || dr[k] !== want || dc[k] - gc[k] != 3 ||
            (k > 0 && (gc[k] - gc[k-1] != 4 || dc[k] - dc[k-1] != 4))) begin
          errors++;
          $display("FAIL b2b_%0d: port=%b res=%h gcyc=%0d dcyc=%0d want port=%0d res=%h spacing 4",
                   k, gp[k], dr[k], gc[k], dc[k], k[0], want);
        end
      end
    end
    @(posedge clock); #2;
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] res; logic own; bit to;
    bit seen;
    @(posedge clock); #1;
    req0 = 1; data0 = 32'h1; amt0 = 5'd20; op0 = 2'b00;
    #1;
    vectors++;
    if (gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_gnt: gnt0=%b want 1", gnt0);
    end
    @(posedge clock); #1; req0 = 0;
    repeat (5) @(posedge clock);
    #1; reset = 1;
    #1;
    vectors++;
    if (result !== 32'h20 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_steps: result=%h busy=%b want 00000020 1", result, busy);
    end
    @(posedge clock); #1; reset = 0;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || owner !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b result=%h owner=%b want 0 0 0 0",
               busy, done, result, owner);
    end
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (done === 1'b1) seen = 1;
      @(posedge clock); #2;
    end
    vectors++;
    if (seen) begin
      errors++;
      $display("FAIL mid_nodone: done=1 want 0 after abort");
    end
    run_op(0, 32'h1, 5'd3, 2'b00, lat, res, own, to);
    vectors++;
    if (to || lat !== 5 || res !== 32'h8) begin
      errors++;
      $display("FAIL mid_after: to=%b lat=%0d res=%h want lat=5 res=00000008",
               to, lat, res);
    end
  endtask

  task automatic test_wait_grant;
    bit          early, gotdone;
    int          t0, lat;
    logic [31:0] r0;
    early = 0; gotdone = 0; r0 = 0;
    @(posedge clock); #1;
    req0 = 1; data0 = 32'h3; amt0 = 5'd2; op0 = 2'b00;
    #1;
    vectors++;
    if (gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL wait_gnt0: gnt0=%b want 1", gnt0);
    end
    @(posedge clock); #1;
    req0 = 0;
    req1 = 1; data1 = 32'hF0000000; amt1 = 5'd4; op1 = 2'b01;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (gnt1 === 1'b1) early = 1;
      if (done === 1'b1) begin
        gotdone = 1; r0 = result;
        break;
      end
      @(posedge clock); #2;
    end
    vectors++;
    if (early || !gotdone || r0 !== 32'hC) begin
      errors++;
      $display("FAIL wait_busy: early_gnt=%b done=%b res=%h want 0 1 0000000c",
               early, gotdone, r0);
    end
    @(posedge clock); #2;
    vectors++;
    if (gnt1 !== 1'b1) begin
      errors++;
      $display("FAIL wait_gnt1: gnt1=%b want 1 after done", gnt1);
    end
    t0 = cyc;
    @(posedge clock); #1;
    req1 = 0; data1 = 32'h0; amt1 = 5'd0;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) break;
      @(posedge clock); #2;
    end
    lat = cyc - t0;
    vectors++;
    if (done !== 1'b1 || lat != 6 || result !== 32'h0F000000 || owner !== 1'b1) begin
      errors++;
      $display("FAIL wait_op1: done=%b lat=%0d res=%h own=%b want 1 6 0f000000 1",
               done, lat, result, owner);
    end
  endtask

  initial begin
    test_reset();
    test_lls();
    test_ars();
    test_rol();
    test_back_to_back();
    test_reset_mid();
    test_wait_grant();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
